fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter sequencer for the 9-bit-ISA core. Owns the PC that indexes
//  the combinational instruction ROM, so the instruction for PC is usable the
//  same cycle. Applies start, stall, halt, absolute and relative branches, and
//  reports run/done status to the top level and testbench.
// PARAMETERS
//  PCW       16  PC width; the ROM is indexed 0 .. 2**PCW-1
//  START_PC  0   PC value loaded by reset
//  OFFW      8   width of the signed relative-branch offset
// PORTS
//  CLK          in   1    system clock; all state updates on rising edge
//  reset        in   1    synchronous, active-high reset
//  start        in   1    1-cycle pulse: begin execution at start_addr
//  start_addr   in   PCW  first PC of the program
//  stall        in   1    hold the current PC; the instruction does not retire
//  halt         in   1    decoded halt for the instruction at PC
//  branch_abs   in   1    taken absolute branch (LUT-resolved target)
//  branch_rel   in   1    taken relative branch
//  target       in   PCW  absolute branch target
//  offset       in   OFFW signed relative offset, two's complement
//  PC           out  PCW  registered program counter, drives the ROM address
//  fetch_valid  out  1    instruction at PC is live (state RUN)
//  done         out  1    program halted; stays high until next start/reset
//  pc_wrap      out  1    sticky flag: sequential increment wrapped to 0
// BEHAVIOUR
//  - Three states: IDLE, RUN, HALTED.
//  - Reset: state=IDLE, PC=START_PC, done=0, pc_wrap=0; fetch_valid=0.
//    Reset wins over every other input and takes effect mid-run at the next edge.
//  - fetch_valid = (state==RUN), combinational from state. done is registered.
//  - IDLE: start -> RUN, PC<=start_addr. All other inputs are ignored.
//  - RUN, stall=1: PC, state and flags hold. halt and branches are ignored;
//    decode re-presents them when stall drops.
//  - RUN, stall=0: the instruction retires. Priority is:
//      halt        -> HALTED, done<=1, PC holds (points at the halt instruction)
//      branch_abs  -> PC<=target (abs wins if branch_rel is also high)
//      branch_rel  -> PC<=PC+sext(offset), mod 2**PCW, no flag raised
//      otherwise   -> PC<=PC+1; if PC was 2**PCW-1, PC<=0 and pc_wrap<=1
//  - start while in RUN is ignored.
//  - HALTED: done=1, PC holds. start -> RUN, PC<=start_addr, done<=0 and
//    pc_wrap<=0 on the same edge.
//  - Latency: a control input sampled at edge N is reflected on PC after edge N.
//    No bubbles, so one instruction retires per non-stalled RUN cycle.
// CONFIGURATION
//  FETCH_RETIRE_CNT_EN defined: adds output retire_cnt [15:0].
//    - Increments on each RUN cycle with stall=0, including the halt cycle.
//    - Saturates at 16'hFFFF.
//    - Cleared by reset and by an accepted start.
//  FETCH_RETIRE_CNT_EN undefined: the port and its counter logic are absent;
//    all other behaviour is identical.
// TESTING
//  1 reset, then start with start_addr=0; no branches -> PC goes 0,1,2,3 on
//    successive edges; fetch_valid=1 from the first RUN cycle.
//  2 RUN at PC=5, branch_abs=1, target=40, branch_rel=1, offset=-3 ->
//    PC=40 next cycle (abs priority).
//  3 RUN at PC=10, branch_rel=1, offset=8'hFD -> PC=7. At PC=2, offset=-5 ->
//    PC=16'hFFFD, pc_wrap stays 0.
//  4 stall=1 for 3 cycles at PC=9 with halt=1 -> PC holds at 9, state RUN;
//    stall drops -> done=1 next cycle, PC=9, fetch_valid=0.
//  5 RUN at PC=16'hFFFF, no branch -> PC=0, pc_wrap=1. start in RUN is
//    ignored. Reset asserted mid-run -> IDLE, PC=START_PC, flags 0.
//  6 [EN] 4 retired instructions plus 2 stall cycles, then halt ->
//    retire_cnt=5. A new start clears it to 0 and done to 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Sequencer bus: decode/control inputs toward fetch_sequencer, PC and status back.
// Zero latency (wires only); no backpressure, stall is carried as a plain control bit.
// Carries retire_cnt only when FETCH_RETIRE_CNT_EN is defined.
interface fetch_sequencer_if #(
  parameter int PCW  = 16,
  parameter int OFFW = 8
);
  logic            start;
  logic [PCW-1:0]  start_addr;
  logic            stall;
  logic            halt;
  logic            branch_abs;
  logic            branch_rel;
  logic [PCW-1:0]  target;
  logic [OFFW-1:0] offset;
  logic [PCW-1:0]  PC;
  logic            fetch_valid;
  logic            done;
  logic            pc_wrap;
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0]     retire_cnt;

  modport master (
    output start, start_addr, stall, halt, branch_abs, branch_rel, target, offset,
    input  PC, fetch_valid, done, pc_wrap, retire_cnt
  );

  modport slave (
    input  start, start_addr, stall, halt, branch_abs, branch_rel, target, offset,
    output PC, fetch_valid, done, pc_wrap, retire_cnt
  );
`else
  modport master (
    output start, start_addr, stall, halt, branch_abs, branch_rel, target, offset,
    input  PC, fetch_valid, done, pc_wrap
  );

  modport slave (
    input  start, start_addr, stall, halt, branch_abs, branch_rel, target, offset,
    output PC, fetch_valid, done, pc_wrap
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer (IDLE/RUN/HALTED) for the 9-bit-ISA core; optional retire counter via FETCH_RETIRE_CNT_EN.
// Latency: controls sampled at edge N appear on PC after edge N; one retire per unstalled RUN cycle.
// Backpressure: stall holds PC, state and flags; halt/branches are ignored while stalled.
module fetch_sequencer #(
  parameter int             PCW      = 16,
  parameter logic [PCW-1:0] START_PC = '0,
  parameter int             OFFW     = 8
) (
  input  logic              CLK,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           done_q, done_d;
  logic           wrap_q, wrap_d;

  logic           retire;
  logic           start_acc;
  logic [PCW-1:0] rel_off;

  assign retire    = (state_q == S_RUN) && !bus.stall;
  assign start_acc = bus.start && (state_q != S_RUN);
  assign rel_off   = PCW'($signed(bus.offset));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    wrap_d  = wrap_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_RUN;
          pc_d    = bus.start_addr;
        end
      end
      S_RUN: begin
        if (retire) begin
          if (bus.halt) begin
            state_d = S_HALTED;
            done_d  = 1'b1;
          end else if (bus.branch_abs) begin
            pc_d = bus.target;
          end else if (bus.branch_rel) begin
            pc_d = pc_q + rel_off;
          end else begin
            pc_d = pc_q + PCW'(1);
            if (pc_q == {PCW{1'b1}}) wrap_d = 1'b1;
          end
        end
      end
      S_HALTED: begin
        // Restart clears both status flags on the same edge the new PC loads.
        if (start_acc) begin
          state_d = S_RUN;
          pc_d    = bus.start_addr;
          done_d  = 1'b0;
          wrap_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_PC;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.fetch_valid = (state_q == S_RUN);
  assign bus.done        = done_q;
  assign bus.pc_wrap     = wrap_q;

`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;

  // Halt cycle counts as a retire; a new program starts counting from zero.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (start_acc) begin
      retire_cnt_d = 16'h0000;
    end else if (retire && (retire_cnt_q != 16'hFFFF)) begin
      retire_cnt_d = retire_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) retire_cnt_q <= 16'h0000;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign bus.retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetch_sequencer;

  localparam int PCW  = 16;
  localparam int OFFW = 8;

  logic CLK;
  logic reset;
  int   errors;
  int   checks;

  fetch_sequencer_if #(.PCW(PCW), .OFFW(OFFW)) bus ();

  fetch_sequencer #(.PCW(PCW), .START_PC(16'h0000), .OFFW(OFFW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.stall      = 1'b0;
    bus.halt       = 1'b0;
    bus.branch_abs = 1'b0;
    bus.branch_rel = 1'b0;
    bus.target     = '0;
    bus.offset     = '0;
  endtask

  task automatic do_start(input logic [PCW-1:0] addr);
    bus.start      = 1'b1;
    bus.start_addr = addr;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.start = 1'b1;
    bus.start_addr = 16'h0077;
    step();
    step();
    bus.start = 1'b0;
    checks++; if (bus.PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", bus.PC); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", bus.fetch_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.pc_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", bus.pc_wrap); end
    reset = 1'b0;
  endtask

  task automatic test_idle_ignores();
    bus.branch_abs = 1'b1;
    bus.target     = 16'h0033;
    bus.halt       = 1'b1;
    step();
    clear_inputs();
    checks++; if (bus.PC !== 16'h0000) begin errors++; $display("FAIL idle_pc got=%h exp=0000", bus.PC); end
    checks++; if (bus.fetch_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL idle_status got fv=%b done=%b exp fv=0 done=0", bus.fetch_valid, bus.done); end
  endtask

  task automatic test_sequential();
    logic [PCW-1:0] exp_pc [4];
    exp_pc[0] = 16'd0; exp_pc[1] = 16'd1; exp_pc[2] = 16'd2; exp_pc[3] = 16'd3;
    do_start(16'h0000);
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv got=%b exp=1", bus.fetch_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.PC !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.PC, exp_pc[i]); end
      if (i < 3) step();
    end
  endtask

  task automatic test_branch_abs();
    reset = 1'b1; step(); reset = 1'b0;
    do_start(16'd5);
    checks++; if (bus.PC !== 16'd5) begin errors++; $display("FAIL abs_start_pc got=%h exp=0005", bus.PC); end
    bus.branch_abs = 1'b1; bus.target = 16'd40;
    bus.branch_rel = 1'b1; bus.offset = 8'hFD;
    step();
    clear_inputs();
    checks++; if (bus.PC !== 16'd40) begin errors++; $display("FAIL abs_priority got=%h exp=0028", bus.PC); end
  endtask

  task automatic test_branch_rel();
    bus.branch_abs = 1'b1; bus.target = 16'd10;
    step();
    clear_inputs();
    bus.branch_rel = 1'b1; bus.offset = 8'hFD;
    step();
    clear_inputs();
    checks++; if (bus.PC !== 16'd7) begin errors++; $display("FAIL rel_back3 got=%h exp=0007", bus.PC); end
    bus.branch_abs = 1'b1; bus.target = 16'd2;
    step();
    clear_inputs();
    bus.branch_rel = 1'b1; bus.offset = 8'hFB;
    step();
    clear_inputs();
    checks++; if (bus.PC !== 16'hFFFD) begin errors++; $display("FAIL rel_wrap_pc got=%h exp=fffd", bus.PC); end
    checks++; if (bus.pc_wrap !== 1'b0) begin errors++; $display("FAIL rel_no_flag got=%b exp=0", bus.pc_wrap); end
    bus.branch_rel = 1'b1; bus.offset = 8'h7F;
    step();
    clear_inputs();
    checks++; if (bus.PC !== 16'h007C) begin errors++; $display("FAIL rel_fwd127 got=%h exp=007c", bus.PC); end
  endtask

  task automatic test_stall_halt();
    bus.branch_abs = 1'b1; bus.target = 16'd9;
    step();
    clear_inputs();
    bus.stall = 1'b1; bus.halt = 1'b1;
    bus.branch_abs = 1'b1; bus.target = 16'd99;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.PC !== 16'd9 || bus.fetch_valid !== 1'b1 || bus.done !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d got pc=%h fv=%b done=%b exp pc=0009 fv=1 done=0", i, bus.PC, bus.fetch_valid, bus.done); end
    end
    bus.stall = 1'b0;
    step();
    clear_inputs();
    checks++; if (bus.done !== 1'b1 || bus.PC !== 16'd9 || bus.fetch_valid !== 1'b0)
      begin errors++; $display("FAIL halt got done=%b pc=%h fv=%b exp done=1 pc=0009 fv=0", bus.done, bus.PC, bus.fetch_valid); end
    step();
    checks++; if (bus.done !== 1'b1 || bus.PC !== 16'd9) begin errors++; $display("FAIL halted_hold got done=%b pc=%h exp done=1 pc=0009", bus.done, bus.PC); end
  endtask

  task automatic test_wrap_restart();
    do_start(16'hFFFF);
    checks++; if (bus.PC !== 16'hFFFF || bus.done !== 1'b0) begin errors++; $display("FAIL restart got pc=%h done=%b exp pc=ffff done=0", bus.PC, bus.done); end
    step();
    checks++; if (bus.PC !== 16'h0000 || bus.pc_wrap !== 1'b1) begin errors++; $display("FAIL seq_wrap got pc=%h wrap=%b exp pc=0000 wrap=1", bus.PC, bus.pc_wrap); end
    do_start(16'h0100);
    checks++; if (bus.PC !== 16'h0001 || bus.pc_wrap !== 1'b1) begin errors++; $display("FAIL start_in_run got pc=%h wrap=%b exp pc=0001 wrap=1", bus.PC, bus.pc_wrap); end
    bus.halt = 1'b1;
    step();
    clear_inputs();
    do_start(16'd20);
    checks++; if (bus.PC !== 16'd20 || bus.done !== 1'b0 || bus.pc_wrap !== 1'b0 || bus.fetch_valid !== 1'b1)
      begin errors++; $display("FAIL halted_start got pc=%h done=%b wrap=%b fv=%b exp pc=0014 done=0 wrap=0 fv=1", bus.PC, bus.done, bus.pc_wrap, bus.fetch_valid); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.PC !== 16'h0000 || bus.fetch_valid !== 1'b0 || bus.done !== 1'b0 || bus.pc_wrap !== 1'b0)
      begin errors++; $display("FAIL midrun_reset got pc=%h fv=%b done=%b wrap=%b exp all 0", bus.PC, bus.fetch_valid, bus.done, bus.pc_wrap); end
  endtask

`ifdef FETCH_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (bus.retire_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d exp=0", bus.retire_cnt); end
    do_start(16'h0000);
    for (int i = 0; i < 4; i++) step();
    bus.stall = 1'b1;
    step();
    step();
    bus.stall = 1'b0;
    checks++; if (bus.retire_cnt !== 16'd4 || bus.PC !== 16'd4) begin errors++; $display("FAIL cnt_stall got cnt=%0d pc=%h exp cnt=4 pc=0004", bus.retire_cnt, bus.PC); end
    bus.halt = 1'b1;
    step();
    clear_inputs();
    checks++; if (bus.retire_cnt !== 16'd5 || bus.done !== 1'b1) begin errors++; $display("FAIL cnt_halt got cnt=%0d done=%b exp cnt=5 done=1", bus.retire_cnt, bus.done); end
    do_start(16'h0010);
    checks++; if (bus.retire_cnt !== 16'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL cnt_restart got cnt=%0d done=%b exp cnt=0 done=0", bus.retire_cnt, bus.done); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_idle_ignores();
    test_sequential();
    test_branch_abs();
    test_branch_rel();
    test_stall_halt();
    test_wrap_restart();
`ifdef FETCH_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
